// File: rtl/reg_dump.sv
// Register-file dump sequencer: reads greg two registers at a time and streams
// every register out as (number, value) words over a valid/ready handshake.
module reg_dump #(
    parameter int unsigned NREG = 32,
    parameter int unsigned DW   = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    output logic [4:0]    read1,
    output logic [4:0]    read2,
    input  logic [DW-1:0] data1,
    input  logic [DW-1:0] data2,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [4:0]    out_num,
    output logic [DW-1:0] out_data,
    output logic          busy,
    output logic          done
);

    localparam int unsigned AW = 5;
    localparam logic [AW-1:0] LAST_BASE = AW'(NREG - 2);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        SEND0,
        SEND1,
        DONE
    } state_t;

    state_t        state, state_n;
    logic [AW-1:0] idx, idx_n;
    logic [DW-1:0] buf1, buf1_n;
    logic [AW-1:0] read1_n, read2_n;
    logic          out_valid_n;
    logic [AW-1:0] out_num_n;
    logic [DW-1:0] out_data_n;
    logic          done_n;

    // State and registered outputs; out_data doubles as the port-1 capture buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            buf1      <= '0;
            read1     <= '0;
            read2     <= '0;
            out_valid <= 1'b0;
            out_num   <= '0;
            out_data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            buf1      <= buf1_n;
            read1     <= read1_n;
            read2     <= read2_n;
            out_valid <= out_valid_n;
            out_num   <= out_num_n;
            out_data  <= out_data_n;
            busy      <= (state_n != IDLE);
            done      <= done_n;
        end
    end

    // Next state plus next values of every registered output.
    always_comb begin
        state_n     = state;
        idx_n       = idx;
        buf1_n      = buf1;
        read1_n     = '0;
        read2_n     = '0;
        out_valid_n = 1'b0;
        out_num_n   = out_num;
        out_data_n  = out_data;
        done_n      = 1'b0;

        unique case (state)
            IDLE: begin
                if (start && !abort) begin
                    idx_n   = '0;
                    read2_n = AW'(1);
                    state_n = READ;
                end
            end
            READ: begin
                buf1_n      = data2;
                out_valid_n = 1'b1;
                out_num_n   = idx;
                out_data_n  = data1;
                state_n     = SEND0;
            end
            SEND0: begin
                out_valid_n = 1'b1;
                if (out_ready) begin
                    out_num_n  = idx + AW'(1);
                    out_data_n = buf1;
                    state_n    = SEND1;
                end
            end
            SEND1: begin
                out_valid_n = 1'b1;
                if (out_ready) begin
                    out_valid_n = 1'b0;
                    if (idx == LAST_BASE) begin
                        done_n  = 1'b1;
                        state_n = DONE;
                    end else begin
                        idx_n   = idx + AW'(2);
                        read1_n = idx_n;
                        read2_n = idx_n + AW'(1);
                        state_n = READ;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Abort wins over everything except reset.
        if (abort && (state != IDLE)) begin
            state_n     = IDLE;
            out_valid_n = 1'b0;
            done_n      = 1'b0;
            read1_n     = '0;
            read2_n     = '0;
        end
    end

endmodule

// File: tb/tb_reg_dump.sv
// Randomized bench for reg_dump: a behavioural greg stand-in feeds the read ports
// and a snapshot model of the register file predicts the dumped word stream.
module tb_reg_dump;

    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst, start, abort, out_ready;
    logic [4:0]    read1, read2, out_num;
    logic [DW-1:0] data1, data2, out_data;
    logic          out_valid, busy, done;

    logic          start4;
    logic [4:0]    read1_4, read2_4, out_num4;
    logic [DW-1:0] data1_4, data2_4, out_data4;
    logic          out_valid4, busy4, done4;

    logic [DW-1:0] regs [32];
    logic [DW-1:0] exp_data [32];
    logic          reg_wr;
    logic [4:0]    wr_num;
    logic [DW-1:0] wr_data;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int t0, stalls, busy_cnt, done_cnt, done_cyc;
    bit hold_pending;
    logic [4:0]    hold_num;
    logic [DW-1:0] hold_data;
    logic [4:0]    got_num [$];
    logic [DW-1:0] got_data [$];

    always #5 clk = ~clk;

    always_comb begin
        data1   = regs[read1];
        data2   = regs[read2];
        data1_4 = regs[read1_4];
        data2_4 = regs[read2_4];
    end

    reg_dump #(.NREG(32), .DW(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .read1(read1), .read2(read2), .data1(data1), .data2(data2),
        .out_valid(out_valid), .out_ready(out_ready), .out_num(out_num),
        .out_data(out_data), .busy(busy), .done(done)
    );

    reg_dump #(.NREG(4), .DW(DW)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .abort(1'b0),
        .read1(read1_4), .read2(read2_4), .data1(data1_4), .data2(data2_4),
        .out_valid(out_valid4), .out_ready(1'b1), .out_num(out_num4),
        .out_data(out_data4), .busy(busy4), .done(done4)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // One clock: greg write and monitoring at the falling edge, inputs change #1 after the rising edge.
    task automatic step();
        @(negedge clk);
        if (reg_wr) regs[wr_num] = wr_data;
        if (hold_pending) begin
            check("hold_valid", 64'(out_valid), 64'(1));
            check("hold_num", 64'(out_num), 64'(hold_num));
            check("hold_data", 64'(out_data), 64'(hold_data));
        end
        hold_pending = 1'b0;
        if (out_valid) begin
            if (out_ready) begin
                got_num.push_back(out_num);
                got_data.push_back(out_data);
            end else begin
                stalls++;
                if (!rst && !abort) begin
                    hold_pending = 1'b1;
                    hold_num     = out_num;
                    hold_data    = out_data;
                end
            end
        end
        if (busy) busy_cnt++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_counters();
        got_num.delete();
        got_data.delete();
        stalls = 0;
        busy_cnt = 0;
        done_cnt = 0;
        done_cyc = -1;
        hold_pending = 1'b0;
    endtask

    task automatic snapshot();
        for (int i = 0; i < 32; i++) exp_data[i] = regs[i];
    endtask

    function automatic logic pick_ready(input int mode, input int i);
        if (mode == 1) return (i % 3 == 1);
        if (mode == 2) return 1'($urandom_range(0, 1));
        return 1'b1;
    endfunction

    task automatic compare_words(input int n);
        check("word_count", 64'(got_num.size()), 64'(n));
        for (int i = 0; i < n && i < got_num.size(); i++) begin
            check($sformatf("num[%0d]", i), 64'(got_num[i]), 64'(i));
            check($sformatf("data[%0d]", i), 64'(got_data[i]), 64'(exp_data[i]));
        end
    endtask

    task automatic run_dump(input int mode, input int abort_at, input bit busy_starts,
                            input int wr_at, input logic [DW-1:0] wr_val);
        bit finished = 1'b0;
        clear_counters();
        t0 = cyc;
        start = 1'b1;
        out_ready = pick_ready(mode, 0);
        step();
        start = 1'b0;
        for (int i = 1; i < 400; i++) begin
            out_ready = pick_ready(mode, i);
            abort     = (i == abort_at);
            start     = busy_starts && (i % 7 == 3);
            reg_wr    = (i == wr_at);
            wr_num    = 5'd4;
            wr_data   = wr_val;
            step();
            if (i == abort_at || done_cnt != 0) begin
                finished = 1'b1;
                break;
            end
        end
        abort = 1'b0;
        start = 1'b0;
        reg_wr = 1'b0;
        out_ready = 1'b1;
        if (!finished) check("dump_timeout", 64'(0), 64'(1));
        if (abort_at > 0) begin
            check("abort_valid", 64'(out_valid), 64'(0));
            check("abort_busy", 64'(busy), 64'(0));
            check("abort_done", 64'(done), 64'(0));
        end else begin
            check("done_count", 64'(done_cnt), 64'(1));
            check("done_cycle", 64'(done_cyc - t0), 64'(49 + stalls));
            check("busy_cycles", 64'(busy_cnt), 64'(49 + stalls));
            step();
            check("done_pulse_end", 64'(done), 64'(0));
            check("busy_end", 64'(busy), 64'(0));
        end
    endtask

    initial begin
        int n4, d4c;
        rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0; start4 = 1'b0;
        reg_wr = 1'b0; wr_num = '0; wr_data = '0;
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        clear_counters();
        #1;
        step();
        step();
        rst = 1'b0;
        check("rst_valid", 64'(out_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_num", 64'(out_num), 64'(0));
        check("rst_data", 64'(out_data), 64'(0));
        check("rst_read1", 64'(read1), 64'(0));
        check("rst_read2", 64'(read2), 64'(0));

        // Write 2333 to r1 through the greg write port, then a full-speed dump.
        reg_wr = 1'b1; wr_num = 5'd1; wr_data = 2333;
        step();
        reg_wr = 1'b0;
        snapshot();
        run_dump(0, 0, 1'b0, 0, '0);
        compare_words(32);

        // Ready pattern 1,0,0 repeating.
        for (int i = 0; i < 32; i++) regs[i] = 32'h1000 + DW'(i);
        snapshot();
        run_dump(1, 0, 1'b0, 0, '0);
        compare_words(32);

        // Random contents, random back-pressure.
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 32; i++) regs[i] = $urandom;
            snapshot();
            run_dump(2, 0, 1'b0, 0, '0);
            compare_words(32);
        end

        // r4 written during pair 2's READ cycle is visible.
        regs[4] = 32'h1234;
        snapshot();
        exp_data[4] = 32'hAAAA;
        run_dump(0, 0, 1'b0, 7, 32'hAAAA);
        compare_words(32);

        // r4 written during pair 2's SEND1 cycle is not.
        regs[4] = 32'h1234;
        snapshot();
        run_dump(0, 0, 1'b0, 9, 32'hAAAA);
        compare_words(32);

        // Abort in SEND1 of pair 5: word 11 still transfers, then the dump ends.
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        snapshot();
        run_dump(0, 18, 1'b0, 0, '0);
        for (int i = 0; i < 3; i++) step();
        check("abort_no_done", 64'(done_cnt), 64'(0));
        compare_words(12);
        snapshot();
        run_dump(0, 0, 1'b0, 0, '0);
        compare_words(32);

        // Start pulses while busy are ignored.
        run_dump(0, 0, 1'b1, 0, '0);
        compare_words(32);
        clear_counters();
        for (int i = 0; i < 3; i++) step();
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("idle_busy_cycles", 64'(busy_cnt), 64'(0));
        check("idle_words", 64'(got_num.size()), 64'(0));
        check("idle_done", 64'(done_cnt), 64'(0));

        // Reset while a word is held in SEND0.
        clear_counters();
        start = 1'b1;
        out_ready = 1'b0;
        step();
        start = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            out_ready = (i < 4);
            step();
        end
        check("pre_rst_valid", 64'(out_valid), 64'(1));
        check("pre_rst_num", 64'(out_num), 64'(2));
        rst = 1'b1;
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        check("mid_rst_valid", 64'(out_valid), 64'(0));
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_done", 64'(done), 64'(0));
        check("mid_rst_num", 64'(out_num), 64'(0));
        check("mid_rst_data", 64'(out_data), 64'(0));
        check("mid_rst_read1", 64'(read1), 64'(0));
        check("mid_rst_read2", 64'(read2), 64'(0));
        step();
        check("mid_rst_no_done", 64'(done_cnt), 64'(0));

        // Four-register instance: 4 words, done in cycle t+7.
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        t0 = cyc;
        start4 = 1'b1;
        step();
        start4 = 1'b0;
        n4 = 0;
        d4c = -1;
        for (int i = 1; i < 30; i++) begin
            if (out_valid4 && n4 < 4) begin
                check($sformatf("n4_num[%0d]", n4), 64'(out_num4), 64'(n4));
                check($sformatf("n4_data[%0d]", n4), 64'(out_data4), 64'(regs[n4]));
                n4++;
            end
            if (done4) d4c = i;
            step();
        end
        check("n4_words", 64'(n4), 64'(4));
        check("n4_done_cycle", 64'(d4c), 64'(7));
        check("n4_busy_end", 64'(busy4), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/reg_dump.md
# reg_dump

Register-file dump sequencer for the MIPS CPU. On a start pulse it drives the two read ports of the `greg` register file and captures the returned pairs. It then streams every register out as (number, value) words over a valid/ready handshake. It sits beside `greg` on the debug/trace path and is the reading end of the register-file interface that the datapath writes through `reg_wr`/`wr_num`/`wr_data`.

## Interface
- `NREG`, 32, number of registers dumped (even, 2..32; indices 0..NREG-1)
- `DW`, 32, register data width
- `clk`  in  1  clock; all state changes on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  begin a dump; sampled only in IDLE
- `abort`  in  1  cancel a dump in progress; returns to IDLE next edge
- `read1`  out  5  `greg` read port 1 register number
- `read2`  out  5  `greg` read port 2 register number
- `data1`  in  DW  `greg` port 1 data, combinational from `read1`
- `data2`  in  DW  `greg` port 2 data, combinational from `read2`
- `out_valid`  out  1  `out_num`/`out_data` hold a word
- `out_ready`  in  1  consumer accepts the word this cycle
- `out_num`  out  5  register number of the current word
- `out_data`  out  DW  register value of the current word
- `busy`  out  1  high whenever the FSM is not in IDLE
- `done`  out  1  one-cycle pulse after the last word is accepted

## Operation
- FSM states: IDLE, READ, SEND0, SEND1, DONE. `idx` is a 5-bit pair base (even).
- IDLE:
  - `read1`=`read2`=0 and `out_valid`=0.
  - `start`=1 and `abort`=0 → `idx`=0, go to READ.
- READ:
  - `read1`=`idx`, `read2`=`idx`+1.
  - At the edge, `data1` → buf0 and `data2` → buf1, then go to SEND0.
- SEND0:
  - `out_valid`=1, `out_num`=`idx`, `out_data`=buf0.
  - `out_ready`=1 → SEND1.
- SEND1:
  - `out_valid`=1, `out_num`=`idx`+1, `out_data`=buf1.
  - `out_ready`=1 and `idx`+1 = NREG-1 → DONE.
  - `out_ready`=1 otherwise → `idx`+=2, READ.
- DONE: `done`=1 for one cycle, then IDLE.
- Handshake rules:
  - A transfer occurs when `out_valid`=1 and `out_ready`=1 at a rising edge.
  - While `out_valid`=1 and the word has not been accepted, `out_num` and `out_data` must not change.
  - `out_valid` never drops without a transfer, except on `abort` or `rst`.
- Output registers: `out_valid`, `out_num`, `out_data` and `done` are registered. `read1`/`read2` may be decoded from state and `idx`, but must be glitch-free at the edge.
- Snapshot semantics:
  - Each pair is sampled in its own READ cycle.
  - A `greg` write committed before that READ edge is visible in the dump; a later write is not.
  - The dump is not atomic across pairs.
- Register 0 is dumped as whatever `greg` returns; `reg_dump` does no forcing.

## Timing
- Reset values: state IDLE, `idx`=0, buf0=buf1=0, `read1`=`read2`=0, `out_valid`=0, `out_num`=0, `out_data`=0, `busy`=0, `done`=0.
- `start` sampled at edge t: READ during cycle t+1, first `out_valid` in cycle t+2.
- With `out_ready` held at 1, each pair takes 3 cycles (READ, SEND0, SEND1).
- For NREG=32 with `start` at edge t:
  - Word 31 is accepted at the end of cycle t+48.
  - `done` is high in cycle t+49.
  - `busy` is high in cycles t+1..t+49.
  - The earliest next `start` is sampled at the end of cycle t+50.
- Back-pressure: each cycle with `out_ready`=0 in SEND0/SEND1 adds one cycle; the word is held unchanged.
- `start` while `busy`=1: ignored, no queuing.
- `abort`:
  - In any non-IDLE state, the next state is IDLE; `out_valid`=0 and `done`=0 in the following cycle.
  - A handshake at the same edge counts as transferred, but the dump still ends.
- Priority: `rst` > `abort` > `start`. `start` and `abort` together in IDLE → stay IDLE.
- `rst` mid-dump: all outputs return to reset values next cycle; no `done`.
- Wrap: `idx` never exceeds NREG-2; there is no wrap to 0 within a dump.

## Test plan
- Reset, then write 2333 to r1 through `greg` (`reg_wr`=1, `wr_num`=1), then `start` with `out_ready`=1 → 32 words, `out_num` 0..31 in order, word 1=2333, all others equal `greg` contents, `done` pulses in cycle t+49.
- Preload r_i=0x1000+i, `out_ready` toggling 1,0,0,1… → same 32 (num, data) pairs in order, each word stable while unaccepted, no duplicates or drops.
- Write r4=0xAAAA during the dump's READ cycle for pair 2 versus during its SEND1 → the first case dumps 0xAAAA at word 4; the second dumps the old r4 value.
- `abort` in SEND1 of pair 5 → `out_valid`=0 next cycle, `busy`=0, no `done`; a new `start` restarts at `out_num`=0.
- `start` pulses while busy, and `start` together with `abort` in IDLE → ignored; exactly one dump runs, or none.
- `rst` asserted during SEND0 with `out_ready`=0 → all outputs return to reset values next cycle; NREG=4 instance dumps 4 words, `done` at t+7.
